sc_statemachine_unaryop: RTL and testbench
==========================================

# sc_statemachine_unaryop

Parametrised microprogrammed controller for the register-file/ALU/shifter datapath. It executes one unary operation per start request: MOV, NEG, ABS or NABS. The source is any BUSA-selectable register and the destination is a runtime-selected general register. The block replaces fixed single-operation sequencers, drives the existing decoder/mux/ALU/shifter control lines, and adds a start/busy/done handshake.

## Interface
- DATAWIDTH_DECODER_SELECTION, 3, write-decoder select width; all-ones = no write
- DATAWIDTH_MUX_SELECTION, 3, BUSA/BUSB mux select width; all-ones = idle
- DATAWIDTH_ALU_SELECTION, 4, ALU opcode width
- DATAWIDTH_REGSHIFTER_SELECTION, 2, shifter mode width
- ALU_PASS, 4'b0000, ALU code for BUSA pass-through
- ALU_NOT, 4'b0011, ALU code for NOT A
- ALU_INC, 4'b1010, ALU code for INC A
- ALU_IDLE, 4'b1111, ALU code driven when no operation is active
- SC_STATEMACHINE_UNARYOP_CLOCK_50  in  1  clock; all state changes on the rising edge
- SC_STATEMACHINE_UNARYOP_Reset_InLow  in  1  asynchronous active-low reset
- SC_STATEMACHINE_UNARYOP_Start_InHigh  in  1  start request, sampled only in IDLE
- SC_STATEMACHINE_UNARYOP_Mode_In  in  2  00 MOV, 01 NEG, 10 ABS, 11 NABS (−|x|)
- SC_STATEMACHINE_UNARYOP_Src_In  in  DATAWIDTH_MUX_SELECTION  source BUSA code
- SC_STATEMACHINE_UNARYOP_Dst_In  in  DATAWIDTH_DECODER_SELECTION  destination decoder code
- SC_STATEMACHINE_UNARYOP_Overflow_InLow, _Negative_InLow  in  1 each  ALU flags, active low
- SC_STATEMACHINE_UNARYOP_DecoderSelectionWrite_Out  out  DATAWIDTH_DECODER_SELECTION
- SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out, _MUXSelectionBUSB_Out  out  DATAWIDTH_MUX_SELECTION each
- SC_STATEMACHINE_UNARYOP_ALUSelection_Out  out  DATAWIDTH_ALU_SELECTION
- SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow  out  1  0 = load shifter
- SC_STATEMACHINE_UNARYOP_RegSHIFTERShiftSelection_OutLow  out  DATAWIDTH_REGSHIFTER_SELECTION  held all-ones (no shift)
- SC_STATEMACHINE_UNARYOP_Busy_Out  out  1  high in every state except IDLE
- SC_STATEMACHINE_UNARYOP_Done_Out  out  1  one-cycle pulse in DONE
- SC_STATEMACHINE_UNARYOP_Error_Out  out  1  overflow flag (see Configuration)

## Operation
- **Idle output vector:** decoder all-ones, both muxes all-ones, ALU_IDLE, load 1, shift all-ones. It is driven in IDLE and DONE, is the reset value of all outputs, and Busy, Done and Error reset to 0.
- **Start capture:** in IDLE, with Start high at an edge, Mode, Src and Dst are latched into internal registers and the state moves to EVAL. Later input changes are ignored until IDLE is reached again.
- **EVAL:** BUSA=Src, ALU_PASS. This produces the sign flag. The negate decision is made here:
  - MOV: negate = 0
  - NEG: negate = 1
  - ABS: negate = (Negative_InLow == 0)
  - NABS: negate = (Negative_InLow == 1)
- **A_SETUP:** BUSA=Src; ALU = ALU_NOT if negate, else ALU_PASS.
- **A_LOAD:** same as A_SETUP, plus load = 0.
- **A_WRITE:** decoder = Dst; the other outputs take idle values.
- **After A_WRITE:** if negate, go to B_SETUP; otherwise go to DONE.
- **B_SETUP:** BUSA = Dst register code (low bits of Dst zero-extended to the mux width); ALU_INC.
- **B_LOAD:** same as B_SETUP, plus load = 0.
- **B_WRITE:** decoder = Dst.
- **Then:** DONE → IDLE.
- **No-write destination:** Dst = all-ones suppresses the write. The sequence still runs to completion and Done still pulses.
- **Unused encodings:** unused state encodings go to IDLE with idle outputs.

## Timing
- Start is seen at edge k; EVAL occupies cycle k+1.
- Non-negate path: Done is high in cycle k+5; Busy is high k+1..k+5.
- Negate path: Done is high in cycle k+8; Busy is high k+1..k+8.
- Back-to-back: the earliest next start is sampled at the edge that leaves DONE for IDLE plus one, i.e. one idle cycle minimum between operations.
- Start while Busy is ignored (not queued).
- Reset asserted mid-operation: outputs return to the idle vector immediately and asynchronously, the state goes to IDLE, and no partial write occurs after reset assertion.
- Negative_InLow is sampled only at the EVAL→A_SETUP edge. Overflow_InLow is sampled only at the B_LOAD→B_WRITE edge.

## Configuration
- **With SC_STATEMACHINE_UNARYOP_OVERFLOW_EN defined:**
  - Error_Out is set when Overflow_InLow == 0 at the B_LOAD→B_WRITE edge (negating the most-negative value).
  - It is held until the next accepted start, which clears it.
  - The result is still written (wrapped).
- **Without the macro:** Error_Out is tied to 0 and Overflow_InLow is unused.

## Test plan
- **ABS, positive source:** RegFIX0 = 5, Mode=10, Src=100, Dst=011, Start → R3 = 5, Done at k+5, no INC step seen.
- **ABS, negative source:** RegFIX0 = −7 (8-bit 0xF9), Mode=10 → NOT, write, INC of R3 sequence; R3 = 7, Done at k+8.
- **NEG and NABS:** NEG of 3 into R1 gives 0xFD. NABS of −4 leaves the value unchanged (−4, MOV path). NABS of 4 gives −4.
- **Start while busy:** Start pulses at k+2 and k+6 with a different Mode/Dst → ignored; only the first operation's write occurs; Done pulses once.
- **Reset mid-op:** Reset_InLow low during A_LOAD → outputs become the idle vector the same cycle, Busy = 0, and the destination register is unchanged.
- **Overflow (macro on):** ABS of 0x80 → Error_Out = 1 after B_LOAD and R3 = 0x80. The next start clears Error. With the macro off, Error stays 0.

Source files
------------

// File: rtl/sc_statemachine_unaryop.sv
// ---------------------------------------------------------------------------
// sc_statemachine_unaryop
//
// Microprogrammed controller that runs one unary operation (MOV, NEG, ABS,
// NABS) on the register-file / ALU / shifter datapath per start request.
// Negation is done in two passes: the source goes through ALU NOT into the
// destination, then the destination goes through ALU INC back into itself.
//
// Optional feature macro: SC_STATEMACHINE_UNARYOP_OVERFLOW_EN
//   defined   : Error_Out flags an overflow seen during the INC pass and
//               holds it until the next accepted start.
//   undefined : Error_Out is tied low and Overflow_InLow is ignored.
//
// Ports
//   SC_STATEMACHINE_UNARYOP_CLOCK_50                   clock, rising edge
//   SC_STATEMACHINE_UNARYOP_Reset_InLow                async reset, active low
//   SC_STATEMACHINE_UNARYOP_Start_InHigh               start, sampled in IDLE
//   SC_STATEMACHINE_UNARYOP_Mode_In                    00 MOV 01 NEG 10 ABS 11 NABS
//   SC_STATEMACHINE_UNARYOP_Src_In                     source BUSA code
//   SC_STATEMACHINE_UNARYOP_Dst_In                     destination decoder code
//   SC_STATEMACHINE_UNARYOP_Overflow_InLow             ALU overflow flag, active low
//   SC_STATEMACHINE_UNARYOP_Negative_InLow             ALU negative flag, active low
//   SC_STATEMACHINE_UNARYOP_DecoderSelectionWrite_Out  write decoder (all-ones = none)
//   SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out       BUSA mux (all-ones = idle)
//   SC_STATEMACHINE_UNARYOP_MUXSelectionBUSB_Out       BUSB mux (all-ones = idle)
//   SC_STATEMACHINE_UNARYOP_ALUSelection_Out           ALU opcode
//   SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow      0 = load shifter
//   SC_STATEMACHINE_UNARYOP_RegSHIFTERShiftSelection_OutLow  shift mode, held all-ones
//   SC_STATEMACHINE_UNARYOP_Busy_Out                   high outside IDLE
//   SC_STATEMACHINE_UNARYOP_Done_Out                   one-cycle completion pulse
//   SC_STATEMACHINE_UNARYOP_Error_Out                  sticky overflow flag
// ---------------------------------------------------------------------------
module sc_statemachine_unaryop #(
    parameter int DATAWIDTH_DECODER_SELECTION    = 3,
    parameter int DATAWIDTH_MUX_SELECTION        = 3,
    parameter int DATAWIDTH_ALU_SELECTION        = 4,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_PASS = 4'b0000,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_NOT  = 4'b0011,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_INC  = 4'b1010,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_IDLE = 4'b1111
) (
    input  logic                                      SC_STATEMACHINE_UNARYOP_CLOCK_50,
    input  logic                                      SC_STATEMACHINE_UNARYOP_Reset_InLow,
    input  logic                                      SC_STATEMACHINE_UNARYOP_Start_InHigh,
    input  logic [1:0]                                SC_STATEMACHINE_UNARYOP_Mode_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_UNARYOP_Src_In,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_STATEMACHINE_UNARYOP_Dst_In,
    input  logic                                      SC_STATEMACHINE_UNARYOP_Overflow_InLow,
    input  logic                                      SC_STATEMACHINE_UNARYOP_Negative_InLow,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_STATEMACHINE_UNARYOP_DecoderSelectionWrite_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_STATEMACHINE_UNARYOP_MUXSelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_STATEMACHINE_UNARYOP_ALUSelection_Out,
    output logic                                      SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_STATEMACHINE_UNARYOP_RegSHIFTERShiftSelection_OutLow,
    output logic                                      SC_STATEMACHINE_UNARYOP_Busy_Out,
    output logic                                      SC_STATEMACHINE_UNARYOP_Done_Out,
    output logic                                      SC_STATEMACHINE_UNARYOP_Error_Out
);

    localparam logic [DATAWIDTH_DECODER_SELECTION-1:0]    DEC_NONE   = '1;
    localparam logic [DATAWIDTH_MUX_SELECTION-1:0]        MUX_IDLE   = '1;
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_NONE = '1;

    localparam logic [1:0] MODE_MOV = 2'b00;
    localparam logic [1:0] MODE_NEG = 2'b01;
    localparam logic [1:0] MODE_ABS = 2'b10;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        EVAL    = 4'd1,
        A_SETUP = 4'd2,
        A_LOAD  = 4'd3,
        A_WRITE = 4'd4,
        B_SETUP = 4'd5,
        B_LOAD  = 4'd6,
        B_WRITE = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]                             mode_reg;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     src_reg;
    logic [DATAWIDTH_DECODER_SELECTION-1:0] dst_reg;
    logic                                   negate_reg;
    logic                                   negate_eval;
    logic                                   accept;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     dst_as_mux;

    assign accept = (state == IDLE) && SC_STATEMACHINE_UNARYOP_Start_InHigh;

    // The INC pass reads the destination back over BUSA, so the decoder code
    // is reused as a mux code (zero-extended or truncated to the mux width).
    assign dst_as_mux = DATAWIDTH_MUX_SELECTION'(dst_reg);

    // State register; reset drops straight to IDLE so the combinational
    // outputs fall to the idle vector without waiting for a clock.
    always_ff @(posedge SC_STATEMACHINE_UNARYOP_CLOCK_50 or negedge SC_STATEMACHINE_UNARYOP_Reset_InLow) begin
        if (!SC_STATEMACHINE_UNARYOP_Reset_InLow) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed microsequence, with the second (INC) pass only
    // taken when the operation needs a two's-complement negation.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? EVAL : IDLE;
            EVAL:    state_next = A_SETUP;
            A_SETUP: state_next = A_LOAD;
            A_LOAD:  state_next = A_WRITE;
            A_WRITE: state_next = negate_reg ? B_SETUP : DONE;
            B_SETUP: state_next = B_LOAD;
            B_LOAD:  state_next = B_WRITE;
            B_WRITE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Negate decision made from the sign flag produced while EVAL passes the
    // source through the ALU.  The flag is active low: 0 means negative.
    always_comb begin
        negate_eval = 1'b0;
        case (mode_reg)
            MODE_MOV: negate_eval = 1'b0;
            MODE_NEG: negate_eval = 1'b1;
            MODE_ABS: negate_eval = ~SC_STATEMACHINE_UNARYOP_Negative_InLow;
            default:  negate_eval = SC_STATEMACHINE_UNARYOP_Negative_InLow;
        endcase
    end

    // Operand capture at the accepted start, and the negate decision latched
    // on leaving EVAL; inputs are ignored for the rest of the operation.
    always_ff @(posedge SC_STATEMACHINE_UNARYOP_CLOCK_50 or negedge SC_STATEMACHINE_UNARYOP_Reset_InLow) begin
        if (!SC_STATEMACHINE_UNARYOP_Reset_InLow) begin
            mode_reg   <= MODE_MOV;
            src_reg    <= MUX_IDLE;
            dst_reg    <= DEC_NONE;
            negate_reg <= 1'b0;
        end else begin
            if (accept) begin
                mode_reg <= SC_STATEMACHINE_UNARYOP_Mode_In;
                src_reg  <= SC_STATEMACHINE_UNARYOP_Src_In;
                dst_reg  <= SC_STATEMACHINE_UNARYOP_Dst_In;
            end
            if (state == EVAL) begin
                negate_reg <= negate_eval;
            end
        end
    end

`ifdef SC_STATEMACHINE_UNARYOP_OVERFLOW_EN
    logic error_reg;

    // Overflow can only arise in the INC pass (negating the most-negative
    // value); the flag is sticky until the next operation is accepted.
    always_ff @(posedge SC_STATEMACHINE_UNARYOP_CLOCK_50 or negedge SC_STATEMACHINE_UNARYOP_Reset_InLow) begin
        if (!SC_STATEMACHINE_UNARYOP_Reset_InLow) begin
            error_reg <= 1'b0;
        end else if (accept) begin
            error_reg <= 1'b0;
        end else if ((state == B_LOAD) && !SC_STATEMACHINE_UNARYOP_Overflow_InLow) begin
            error_reg <= 1'b1;
        end
    end

    assign SC_STATEMACHINE_UNARYOP_Error_Out = error_reg;
`else
    logic unused_overflow;
    assign unused_overflow                   = SC_STATEMACHINE_UNARYOP_Overflow_InLow;
    assign SC_STATEMACHINE_UNARYOP_Error_Out = 1'b0;
`endif

    // Output decode: every state starts from the idle vector and overrides
    // only the control lines its micro-step needs.
    always_comb begin
        SC_STATEMACHINE_UNARYOP_DecoderSelectionWrite_Out       = DEC_NONE;
        SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out            = MUX_IDLE;
        SC_STATEMACHINE_UNARYOP_MUXSelectionBUSB_Out            = MUX_IDLE;
        SC_STATEMACHINE_UNARYOP_ALUSelection_Out                = ALU_IDLE;
        SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow           = 1'b1;
        SC_STATEMACHINE_UNARYOP_RegSHIFTERShiftSelection_OutLow = SHIFT_NONE;
        SC_STATEMACHINE_UNARYOP_Busy_Out                        = 1'b0;
        SC_STATEMACHINE_UNARYOP_Done_Out                        = 1'b0;
        case (state)
            IDLE: begin
            end
            EVAL: begin
                SC_STATEMACHINE_UNARYOP_Busy_Out             = 1'b1;
                SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out = src_reg;
                SC_STATEMACHINE_UNARYOP_ALUSelection_Out     = ALU_PASS;
            end
            A_SETUP, A_LOAD: begin
                SC_STATEMACHINE_UNARYOP_Busy_Out              = 1'b1;
                SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out  = src_reg;
                SC_STATEMACHINE_UNARYOP_ALUSelection_Out      = negate_reg ? ALU_NOT : ALU_PASS;
                SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow = (state != A_LOAD);
            end
            A_WRITE, B_WRITE: begin
                SC_STATEMACHINE_UNARYOP_Busy_Out                  = 1'b1;
                SC_STATEMACHINE_UNARYOP_DecoderSelectionWrite_Out = dst_reg;
            end
            B_SETUP, B_LOAD: begin
                SC_STATEMACHINE_UNARYOP_Busy_Out              = 1'b1;
                SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out  = dst_as_mux;
                SC_STATEMACHINE_UNARYOP_ALUSelection_Out      = ALU_INC;
                SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow = (state != B_LOAD);
            end
            DONE: begin
                SC_STATEMACHINE_UNARYOP_Busy_Out = 1'b1;
                SC_STATEMACHINE_UNARYOP_Done_Out = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sc_statemachine_unaryop.sv
// ---------------------------------------------------------------------------
// tb_sc_statemachine_unaryop
//
// Bench for sc_statemachine_unaryop.  A small 8-bit register file / ALU /
// shifter model is driven by the controller outputs and feeds the flags back,
// so results land in real registers.  An operation-level model predicts
// busy/done/error timing and the final register contents from the
// arithmetic meaning of each mode.
// ---------------------------------------------------------------------------
module tb_sc_statemachine_unaryop;

    localparam logic [3:0] ALU_PASS_C = 4'b0000;
    localparam logic [3:0] ALU_NOT_C  = 4'b0011;
    localparam logic [3:0] ALU_INC_C  = 4'b1010;

`ifdef SC_STATEMACHINE_UNARYOP_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [2:0] src;
    logic [2:0] dst;
    logic       ovf_n;
    logic       neg_n;
    logic [2:0] dec;
    logic [2:0] busa;
    logic [2:0] busb;
    logic [3:0] alu;
    logic       load_n;
    logic [1:0] shift;
    logic       busy;
    logic       done;
    logic       error;

    int total = 0;
    int bad   = 0;

    sc_statemachine_unaryop dut (
        .SC_STATEMACHINE_UNARYOP_CLOCK_50                       (clk),
        .SC_STATEMACHINE_UNARYOP_Reset_InLow                    (rst_n),
        .SC_STATEMACHINE_UNARYOP_Start_InHigh                   (start),
        .SC_STATEMACHINE_UNARYOP_Mode_In                        (mode),
        .SC_STATEMACHINE_UNARYOP_Src_In                         (src),
        .SC_STATEMACHINE_UNARYOP_Dst_In                         (dst),
        .SC_STATEMACHINE_UNARYOP_Overflow_InLow                 (ovf_n),
        .SC_STATEMACHINE_UNARYOP_Negative_InLow                 (neg_n),
        .SC_STATEMACHINE_UNARYOP_DecoderSelectionWrite_Out      (dec),
        .SC_STATEMACHINE_UNARYOP_MUXSelectionBUSA_Out           (busa),
        .SC_STATEMACHINE_UNARYOP_MUXSelectionBUSB_Out           (busb),
        .SC_STATEMACHINE_UNARYOP_ALUSelection_Out               (alu),
        .SC_STATEMACHINE_UNARYOP_RegSHIFTERLoad_OutLow          (load_n),
        .SC_STATEMACHINE_UNARYOP_RegSHIFTERShiftSelection_OutLow(shift),
        .SC_STATEMACHINE_UNARYOP_Busy_Out                       (busy),
        .SC_STATEMACHINE_UNARYOP_Done_Out                       (done),
        .SC_STATEMACHINE_UNARYOP_Error_Out                      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: register file, ALU and shifter register.
    logic [7:0] regs [8];
    logic [7:0] shreg;
    logic [7:0] busa_val;
    logic [7:0] alu_res;
    logic       poke_en;
    logic [2:0] poke_idx;
    logic [7:0] poke_val;

    always_comb begin
        busa_val = (busa == 3'h7) ? 8'h00 : regs[busa];
        case (alu)
            ALU_PASS_C: alu_res = busa_val;
            ALU_NOT_C:  alu_res = ~busa_val;
            ALU_INC_C:  alu_res = busa_val + 8'h01;
            default:    alu_res = 8'h00;
        endcase
    end

    assign neg_n = ~alu_res[7];
    assign ovf_n = ~((alu == ALU_INC_C) && (busa_val == 8'h7F));

    always @(posedge clk) begin
        if (poke_en) begin
            regs[poke_idx] <= poke_val;
        end else if (dec != 3'h7) begin
            regs[dec] <= shreg;
        end
        if (!load_n) begin
            shreg <= alu_res;
        end
    end

    // Operation-level reference model.
    function automatic bit wants_negate(input logic [1:0] m, input logic [7:0] x);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return x[7];
            default: return !x[7];
        endcase
    endfunction

    function automatic logic [7:0] unary_result(input logic [1:0] m, input logic [7:0] x);
        return wants_negate(m, x) ? (8'h00 - x) : x;
    endfunction

    int         m_cyc;
    int         m_lat;
    logic [2:0] m_dst;
    logic [7:0] m_exp;
    bit         m_neg;
    bit         m_ovf;
    bit         m_err;
    logic [7:0] snap [8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0;
            m_lat <= 5;
            m_dst <= 3'h7;
            m_exp <= 8'h00;
            m_neg <= 1'b0;
            m_ovf <= 1'b0;
            m_err <= 1'b0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc <= 1;
                m_dst <= dst;
                m_exp <= unary_result(mode, regs[src]);
                m_neg <= wants_negate(mode, regs[src]);
                m_lat <= wants_negate(mode, regs[src]) ? 8 : 5;
                m_ovf <= wants_negate(mode, regs[src]) && (regs[src] == 8'h80) && (dst != 3'h7);
                m_err <= 1'b0;
                snap  <= regs;
            end
        end else if (m_cyc == m_lat) begin
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc == 6 && m_ovf) begin
                m_err <= OVF_EN;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    task automatic compare_loop();
        bit saw_inc;
        bit exp_busy;
        bit exp_done;
        int diffs;
        saw_inc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_busy = (m_cyc != 0);
                exp_done = (m_cyc != 0) && (m_cyc == m_lat);
                if (m_cyc == 1) saw_inc = 1'b0;
                if (exp_busy && alu == ALU_INC_C) saw_inc = 1'b1;
                checkOutput("busy", 32'(busy), 32'(exp_busy));
                checkOutput("done", 32'(done), 32'(exp_done));
                checkOutput("error", 32'(error), 32'(m_err));
                if (!exp_busy || exp_done) begin
                    checkOutput("idle_vector", 32'({dec, busa, busb, alu, load_n, shift}), 32'hFFFF);
                end
                if (exp_done) begin
                    checkOutput("inc_pass", 32'(saw_inc), 32'(m_neg));
                    if (m_dst != 3'h7) begin
                        checkOutput("result", 32'(regs[m_dst]), 32'(m_exp));
                    end
                    diffs = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (i != int'(m_dst) && regs[i] !== snap[i]) diffs++;
                    end
                    checkOutput("others_kept", 32'(diffs), 32'd0);
                end
            end
        end
    endtask

    task automatic pokeReg(input int idx, input logic [7:0] val);
        @(negedge clk);
        start    = 1'b0;
        poke_en  = 1'b1;
        poke_idx = 3'(idx);
        poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issues one start and returns the cycle (relative to the start edge) in
    // which Done was seen, or -1 if it never came within the budget.
    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] s, input logic [2:0] d, output int lat);
        int n;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        src   = s;
        dst   = d;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = done ? n : -1;
    endtask

    logic [7:0] boundary [6];

    initial begin
        int lat;
        int pulses;
        boundary[0] = 8'h00; boundary[1] = 8'h7F; boundary[2] = 8'h80;
        boundary[3] = 8'hFF; boundary[4] = 8'h01; boundary[5] = 8'h81;

        rst_n = 1'b0; start = 1'b0; mode = 2'b00; src = 3'h0; dst = 3'h7;
        poke_en = 1'b0; poke_idx = 3'h0; poke_val = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_idle_vector", 32'({dec, busa, busb, alu, load_n, shift}), 32'hFFFF);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        fork
            compare_loop();
        join_none

        for (int i = 0; i < 8; i++) pokeReg(i, 8'(8'h10 + i));

        $display("[TB] directed operations");
        pokeReg(4, 8'd5);
        applyStimulus(2'b10, 3'd4, 3'd3, lat);
        checkOutput("abs_pos_latency", 32'(lat), 32'd5);
        checkOutput("abs_pos_r3", 32'(regs[3]), 32'h05);

        pokeReg(4, 8'hF9);
        applyStimulus(2'b10, 3'd4, 3'd3, lat);
        checkOutput("abs_neg_latency", 32'(lat), 32'd8);
        checkOutput("abs_neg_r3", 32'(regs[3]), 32'h07);

        pokeReg(2, 8'd3);
        applyStimulus(2'b01, 3'd2, 3'd1, lat);
        checkOutput("neg3_r1", 32'(regs[1]), 32'hFD);

        pokeReg(5, 8'hFC);
        applyStimulus(2'b11, 3'd5, 3'd6, lat);
        checkOutput("nabs_neg_latency", 32'(lat), 32'd5);
        checkOutput("nabs_neg_r6", 32'(regs[6]), 32'hFC);

        pokeReg(5, 8'h04);
        applyStimulus(2'b11, 3'd5, 3'd6, lat);
        checkOutput("nabs_pos_r6", 32'(regs[6]), 32'hFC);

        pokeReg(4, 8'h80);
        applyStimulus(2'b10, 3'd4, 3'd3, lat);
        checkOutput("abs_min_r3", 32'(regs[3]), 32'h80);
        checkOutput("abs_min_error", 32'(error), 32'(OVF_EN));

        pokeReg(4, 8'h01);
        applyStimulus(2'b00, 3'd4, 3'd2, lat);
        checkOutput("mov_r2", 32'(regs[2]), 32'h01);
        checkOutput("error_cleared", 32'(error), 32'd0);

        pokeReg(0, 8'h11);
        applyStimulus(2'b01, 3'd0, 3'd7, lat);
        checkOutput("nowrite_latency", 32'(lat), 32'd8);

        $display("[TB] start while busy");
        pokeReg(5, 8'h55);
        pokeReg(4, 8'hF0);
        @(negedge clk);
        start = 1'b1; mode = 2'b01; src = 3'd4; dst = 3'd3;
        @(negedge clk);
        pulses = 0;
        for (int n = 1; n <= 12; n++) begin
            if (done) pulses++;
            start = (n == 2 || n == 6);
            mode  = 2'b00;
            dst   = 3'd5;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("busy_ignore_pulses", 32'(pulses), 32'd1);
        checkOutput("busy_ignore_r3", 32'(regs[3]), 32'h10);
        checkOutput("busy_ignore_r5", 32'(regs[5]), 32'h55);

        $display("[TB] reset mid-operation");
        pokeReg(3, 8'h33);
        pokeReg(4, 8'h12);
        @(negedge clk);
        start = 1'b1; mode = 2'b01; src = 3'd4; dst = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_idle_vector", 32'({dec, busa, busb, alu, load_n, shift}), 32'hFFFF);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_r3_kept", 32'(regs[3]), 32'h33);

        $display("[TB] random operations");
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            poke_en = 1'b0;
            if (m_cyc == 0 && $urandom_range(0, 5) == 0) begin
                start    = 1'b0;
                poke_en  = 1'b1;
                poke_idx = 3'($urandom_range(0, 6));
                poke_val = ($urandom_range(0, 1) == 0) ? boundary[$urandom_range(0, 5)] : 8'($urandom);
            end else begin
                start = ($urandom_range(0, 2) == 0);
                mode  = 2'($urandom);
                src   = 3'($urandom_range(0, 6));
                dst   = 3'($urandom_range(0, 7));
            end
        end
        @(negedge clk);
        start   = 1'b0;
        poke_en = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
